regfile_2r1w: RTL and testbench

Parametrised register file for the calculator datapath: DEPTH words of WIDTH bits, one write port and two independent read ports (A and B operand buses). Read outputs are released to high impedance when their port is not enabled, so they can share operand buses with other sources. Adds synchronous reset, optional write-through bypass, a sequenced clear sweep with busy status, and a dropped-write indicator.

---
 rtl/regfile_2r1w.sv | 217 +++++++++++++++++++++
 tb/tb_regfile_2r1w.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// ---------------------------------------------------------------------------
// regfile_2r1w
//
// Register file for the calculator datapath: DEPTH words of WIDTH bits with
// one write port and two independent combinational read ports (A, B). Each
// read bus floats to Z while its port is disabled, so it can share an operand
// bus with other sources.
//
// All state changes on the FALLING edge of clk. Reset is synchronous and
// active high, and it is sampled on that same edge.
//
// Features:
//   - optional write-through bypass (BYPASS=1): an accepted write is visible
//     on a matching read port in the same cycle, before the edge
//   - clear sweep: clr_start zeroes one entry per cycle, with busy high
//   - wr_drop: registered flag for a write request that was refused
//
// Ports:
//   clk, rst            clock (falling-edge active), sync active-high reset
//   we, wa, wd          write request, address, data
//   re_a, ra_a, rd_a    port A enable, address, data (Z when re_a=0)
//   re_b, ra_b, rd_b    port B enable, address, data (Z when re_b=0)
//   clr_start           request a clear sweep (ignored while one is running)
//   busy                clear sweep in progress (flop output)
//   wr_drop             previous edge dropped a write (flop output)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// regfile_2r1w_rd_port
//
// Value mux for one read port. Enable and tristate handling stay in the top.
//   ra      read address
//   mem     flattened storage
//   fwd_en  an accepted write may be forwarded (bypass enabled and accepted)
//   wa, wd  write address / data of the current cycle
//   rdata   selected word; 0 for an out-of-range address
// ---------------------------------------------------------------------------
module regfile_2r1w_rd_port #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic [AW-1:0]                ra,
   input  logic [DEPTH-1:0][WIDTH-1:0]  mem,
   input  logic                         fwd_en,
   input  logic [AW-1:0]                wa,
   input  logic [WIDTH-1:0]             wd,
   output logic [WIDTH-1:0]             rdata
);

   // The compare loop is used instead of mem[ra] so that addresses at or
   // above DEPTH fall through to 0. It also avoids an index whose width
   // differs from the array range when DEPTH is not a power of two.
   always_comb begin
      rdata = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ra == AW'(i)) rdata = mem[i];
      end
      // fwd_en implies wa < DEPTH, so a match also means ra is in range.
      if (fwd_en && (wa == ra)) rdata = wd;
   end

endmodule

module regfile_2r1w #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 16,
   parameter int AW     = 4,
   parameter int BYPASS = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    wa,
   input  logic [WIDTH-1:0] wd,
   input  logic             re_a,
   input  logic [AW-1:0]    ra_a,
   output logic [WIDTH-1:0] rd_a,
   input  logic             re_b,
   input  logic [AW-1:0]    ra_b,
   output logic [WIDTH-1:0] rd_b,
   input  logic             clr_start,
   output logic             busy,
   output logic             wr_drop
);

   localparam int NUM_RD = 2;

   // DEPTH may equal 2**AW, so the range compare needs one extra bit.
   localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t                      state_q, state_d;
   logic [AW-1:0]               ptr_q, ptr_d;
   logic                        busy_q, busy_d;
   logic                        wr_drop_q, wr_drop_d;
   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

   logic wa_in_range;
   logic wr_acc;
   logic sweep_last;
   logic fwd_en;

   assign wa_in_range = ({1'b0, wa} < DEPTH_L);
   // clr_start wins over a same-cycle write, and writes are refused while
   // the sweep runs.
   assign wr_acc      = (state_q == ST_IDLE) && !clr_start && we && wa_in_range;
   assign sweep_last  = (ptr_q == LAST_PTR);
   assign fwd_en      = (BYPASS != 0) && wr_acc;

   // ------------------------------------------------------------------
   // State register (falling edge, synchronous reset)
   // ------------------------------------------------------------------
   always_ff @(negedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         busy_q    <= 1'b0;
         wr_drop_q <= 1'b0;
         mem_q     <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         busy_q    <= busy_d;
         wr_drop_q <= wr_drop_d;
         mem_q     <= mem_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (clr_start) begin
               state_d = ST_CLEAR;
               ptr_d   = '0;
            end
         end
         ST_CLEAR: begin
            // clr_start is ignored here, so the sweep never restarts.
            if (sweep_last) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ptr_d   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output / datapath logic
   // ------------------------------------------------------------------
   always_comb begin
      // busy is registered from the next state. It rises on the edge that
      // samples clr_start and falls on the edge that clears DEPTH-1.
      busy_d    = (state_d == ST_CLEAR);
      wr_drop_d = we && !wr_acc;

      mem_d = mem_q;
      for (int i = 0; i < DEPTH; i++) begin
         if ((state_q == ST_CLEAR) && (ptr_q == AW'(i))) begin
            mem_d[i] = '0;
         end else if (wr_acc && (wa == AW'(i))) begin
            mem_d[i] = wd;
         end
      end
   end

   assign busy    = busy_q;
   assign wr_drop = wr_drop_q;

   // ------------------------------------------------------------------
   // Read ports
   // ------------------------------------------------------------------
   logic [NUM_RD-1:0][AW-1:0]    rd_addr;
   logic [NUM_RD-1:0][WIDTH-1:0] rd_val;

   assign rd_addr[0] = ra_a;
   assign rd_addr[1] = ra_b;

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      regfile_2r1w_rd_port #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH),
         .AW    (AW)
      ) u_rd (
         .ra     (rd_addr[p]),
         .mem    (mem_q),
         .fwd_en (fwd_en),
         .wa     (wa),
         .wd     (wd),
         .rdata  (rd_val[p])
      );
   end

   // Disabled ports release the shared operand bus.
   assign rd_a = re_a ? rd_val[0] : {WIDTH{1'bz}};
   assign rd_b = re_b ? rd_val[1] : {WIDTH{1'bz}};

endmodule

// File: tb/tb_regfile_2r1w.sv
// ---------------------------------------------------------------------------
// tb_regfile_2r1w
//
// Two instances driven from the same stimulus:
//   u0: DEPTH=16, BYPASS=1
//   u1: DEPTH=12, BYPASS=0 (addresses 12..15 are out of range)
// A behavioural model holds an array per instance plus a sweep position.
// One compare process checks both instances on every cycle after reset.
// Directed literal checks pin the model on the interesting cases.
// When a port is disabled, the bench drives its own pattern onto the shared
// bus. The bus must then carry exactly that pattern.
// ---------------------------------------------------------------------------
module tb_regfile_2r1w;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, we, re_a, re_b, clr_start;
   logic [3:0]  wa, ra_a, ra_b;
   logic [31:0] wd, pat_a, pat_b;
   wire  [31:0] a0, b0, a1, b1;
   logic        busy0, busy1, drop0, drop1;

   // Other bus sources, active only while the port is disabled.
   assign a0 = re_a ? 32'bz : pat_a;
   assign a1 = re_a ? 32'bz : pat_a;
   assign b0 = re_b ? 32'bz : pat_b;
   assign b1 = re_b ? 32'bz : pat_b;

   regfile_2r1w #(.WIDTH(32), .DEPTH(16), .AW(4), .BYPASS(1)) u0 (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
      .re_a(re_a), .ra_a(ra_a), .rd_a(a0),
      .re_b(re_b), .ra_b(ra_b), .rd_b(b0),
      .clr_start(clr_start), .busy(busy0), .wr_drop(drop0));

   regfile_2r1w #(.WIDTH(32), .DEPTH(12), .AW(4), .BYPASS(0)) u1 (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
      .re_a(re_a), .ra_a(ra_a), .rd_a(a1),
      .re_b(re_b), .ra_b(ra_b), .rd_b(b1),
      .clr_start(clr_start), .busy(busy1), .wr_drop(drop1));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input int u, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s u%0d at %0t: got %h expected %h", nm, u, $time, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model
   // ------------------------------------------------------------------
   logic [31:0] mm [2][16];
   int          pos   [2] = '{-1, -1};   // next entry to clear, -1 when idle
   bit          mdrop [2] = '{0, 0};
   int          dep   [2] = '{16, 12};
   bit          byp   [2] = '{1, 0};
   bit          mvalid = 0;

   function automatic logic [31:0] exp_rd(input int u, input logic [3:0] ra);
      if (int'(ra) >= dep[u]) return 32'h0;
      if (byp[u] && pos[u] < 0 && !clr_start && we && int'(wa) < dep[u] && wa == ra)
         return wd;
      return mm[u][ra];
   endfunction

   task automatic model_step();
      for (int u = 0; u < 2; u++) begin
         if (rst) begin
            for (int k = 0; k < 16; k++) mm[u][k] = 32'h0;
            pos[u]   = -1;
            mdrop[u] = 0;
         end else if (pos[u] >= 0) begin
            mm[u][pos[u]] = 32'h0;
            pos[u]++;
            if (pos[u] == dep[u]) pos[u] = -1;
            mdrop[u] = we;
         end else if (clr_start) begin
            pos[u]   = 0;
            mdrop[u] = we;
         end else if (we && int'(wa) < dep[u]) begin
            mm[u][wa] = wd;
            mdrop[u]  = 0;
         end else begin
            mdrop[u] = we;
         end
      end
      if (rst) mvalid = 1;
   endtask

   initial forever begin
      @(negedge clk);
      model_step();
   end

   // Per-cycle compare, well away from the falling edge.
   initial forever begin
      @(posedge clk);
      #2;
      if (mvalid) begin
         for (int u = 0; u < 2; u++) begin
            chk("busy",    u, 32'(u == 0 ? busy0 : busy1), 32'(pos[u] >= 0));
            chk("wr_drop", u, 32'(u == 0 ? drop0 : drop1), 32'(mdrop[u]));
            chk("rd_a",    u, u == 0 ? a0 : a1, re_a ? exp_rd(u, ra_a) : pat_a);
            chk("rd_b",    u, u == 0 ? b0 : b1, re_b ? exp_rd(u, ra_b) : pat_b);
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
   endtask

   task automatic idle();
      rst = 0; we = 0; wa = 0; wd = 0; clr_start = 0;
      re_a = 1; re_b = 1; ra_a = 0; ra_b = 0;
      pat_a = $urandom; pat_b = $urandom;
   endtask

   int bc0, bc1;

   initial begin
      idle();
      rst = 1;
      tick(); rst = 1;
      tick(); idle();

      // Reset then read every address on both ports.
      for (int i = 0; i < 16; i++) begin
         tick(); idle(); ra_a = 4'(i); ra_b = 4'(15 - i);
         #3;
         chk("rst_rd_a", 0, a0, 32'h0);
         chk("rst_rd_b", 1, b1, 32'h0);
         chk("rst_busy", 0, 32'(busy0), 32'h0);
         chk("rst_drop", 0, 32'(drop0), 32'h0);
      end

      // Write and read back. Reg 15 is out of range for u1.
      tick(); idle(); we = 1; wa = 4'd3;  wd = 32'hDEADBEEF;
      tick(); idle(); we = 1; wa = 4'd15; wd = 32'h12345678;
      tick(); idle(); ra_a = 4'd3; ra_b = 4'd15;
      #3;
      chk("wr_rd_a", 0, a0, 32'hDEADBEEF);
      chk("wr_rd_b", 0, b0, 32'h12345678);
      chk("wr_rd_a", 1, a1, 32'hDEADBEEF);
      chk("oor_rd_b", 1, b1, 32'h0);
      chk("oor_drop", 1, 32'(drop1), 32'h1);
      chk("ok_drop", 0, 32'(drop0), 32'h0);
      tick(); idle(); re_a = 0; pat_a = 32'h5A5A0F0F; ra_b = 4'd3;
      #3;
      chk("hiz_a", 0, a0, 32'h5A5A0F0F);
      chk("hiz_a", 1, a1, 32'h5A5A0F0F);

      // Bypass: u0 forwards in the same cycle, u1 shows the old value.
      tick(); idle(); we = 1; wa = 4'd5; wd = 32'hA5A5A5A5; ra_a = 4'd5;
      #3;
      chk("byp_rd_a", 0, a0, 32'hA5A5A5A5);
      chk("nobyp_rd_a", 1, a1, 32'h0);
      tick(); idle(); ra_a = 4'd5;
      #3;
      chk("nobyp_after", 1, a1, 32'hA5A5A5A5);

      // Clear sweep.
      for (int i = 0; i < 16; i++) begin
         tick(); idle(); we = 1; wa = 4'(i); wd = 32'hFFFFFFFF;
      end
      tick(); idle(); clr_start = 1; we = 1; wa = 4'd4; wd = 32'h00001234;
      bc0 = 0; bc1 = 0;
      for (int j = 0; j < 20; j++) begin
         tick(); idle(); ra_a = 4'd7; ra_b = 4'd2;
         we = (j <= 16);
         wa = (j < 16) ? 4'(j) : 4'd2;
         wd = (j == 16) ? 32'h0BADF00D : $urandom;
         clr_start = (j == 3);
         #3;
         bc0 += int'(busy0);
         bc1 += int'(busy1);
         if (j == 0)  chk("clr_drop", 0, 32'(drop0), 32'h1);
         if (j == 7)  chk("clr_reg7_old", 0, a0, 32'hFFFFFFFF);
         if (j == 8)  chk("clr_reg7_zero", 0, a0, 32'h0);
         if (j == 17) chk("post_clr_wr", 0, b0, 32'h0BADF00D);
         if (j == 17) chk("post_clr_drop", 0, 32'(drop0), 32'h0);
      end
      chk("busy_cycles", 0, 32'(bc0), 32'd16);
      chk("busy_cycles", 1, 32'(bc1), 32'd12);

      // Reset in the middle of a sweep.
      tick(); idle(); clr_start = 1;
      for (int j = 0; j < 5; j++) begin
         tick(); idle(); we = 1; wa = 4'(j); wd = $urandom;
      end
      tick(); idle(); rst = 1;
      tick(); idle(); we = 1; wa = 4'd9; wd = 32'h13579BDF;
      #3;
      chk("midrst_busy", 0, 32'(busy0), 32'h0);
      for (int i = 0; i < 16; i++) begin
         tick(); idle(); ra_b = 4'(i);
         #3;
         chk("midrst_rd", 0, b0, (i == 9) ? 32'h13579BDF : 32'h0);
      end

      // Out-of-range write on u1.
      tick(); idle(); we = 1; wa = 4'd13; wd = 32'hCAFEF00D; ra_b = 4'd13;
      tick(); idle(); ra_b = 4'd13;
      #3;
      chk("oor13_drop", 1, 32'(drop1), 32'h1);
      chk("oor13_drop", 0, 32'(drop0), 32'h0);
      chk("oor13_rd", 1, b1, 32'h0);
      chk("oor13_rd", 0, b0, 32'hCAFEF00D);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         tick(); idle();
         rst       = ($urandom % 100) == 0;
         clr_start = ($urandom % 40) == 0;
         we        = !rst && ($urandom % 2 == 1);
         wa        = 4'($urandom);
         wd        = $urandom;
         re_a      = ($urandom % 4) != 0;
         re_b      = ($urandom % 4) != 0;
         ra_a      = ($urandom % 2 == 1) ? wa : 4'($urandom);
         ra_b      = 4'($urandom);
      end

      tick(); idle();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
